aer_link_arbiter: RTL

Shares the single 10-bit AER input link of the SNN core between two requesters: the rank-order (ROC) image encoder and the host configuration path. It captures one event per requester and drives a four-phase REQ/ACK handshake toward the core. Each requester gets its own busy flag, which it uses as its AER-busy input. It sits between the encoder/host and the core's AER input controller and replaces the direct encoder-to-core connection.

---
 rtl/aer_arb_pkg.sv | 9 +
 rtl/aer_req_slot.sv | 41 ++++
 rtl/aer_link_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/aer_arb_pkg.sv
// Shared types and defaults for the AER link arbiter.
package aer_arb_pkg;

  typedef enum logic [1:0] {IDLE, REQ, RELEASE} arb_state_t;
  typedef enum logic {GRANT_ENC, GRANT_HOST} grant_t;

  localparam int unsigned AER_W_DEFAULT = 10;

endpackage

// File: rtl/aer_req_slot.sv
// One-entry event slot: VALID rising-edge capture, pending flag, overrun pulse.
module aer_req_slot
  import aer_arb_pkg::*;
#(
  parameter int unsigned AER_W = AER_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             VALID,
  input  logic [AER_W-1:0] ADDR,
  input  logic             CLR,
  output logic             PENDING,
  output logic [AER_W-1:0] SLOT_ADDR,
  output logic             OVERRUN
);

  logic valid_d;
  logic rise_c;

  assign rise_c = VALID & ~valid_d;

  // A clear in the same cycle as a new edge frees the slot for that edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_d   <= 1'b0;
      PENDING   <= 1'b0;
      SLOT_ADDR <= '0;
      OVERRUN   <= 1'b0;
    end else begin
      valid_d <= VALID;
      OVERRUN <= rise_c & PENDING & ~CLR;
      if (rise_c && (!PENDING || CLR)) begin
        PENDING   <= 1'b1;
        SLOT_ADDR <= ADDR;
      end else if (CLR) begin
        PENDING <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/aer_link_arbiter.sv
// Arbitrates the encoder and host event slots onto one four-phase AER link,
// with per-phase timeout and sticky error flags.
module aer_link_arbiter
  import aer_arb_pkg::*;
#(
  parameter int unsigned AER_W       = AER_W_DEFAULT,
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [AER_W-1:0] ENC_ADDR,
  input  logic             ENC_VALID,
  output logic             ENC_BUSY,
  input  logic [AER_W-1:0] HOST_ADDR,
  input  logic             HOST_VALID,
  output logic             HOST_BUSY,
  output logic [AER_W-1:0] AERIN_ADDR,
  output logic             AERIN_REQ,
  input  logic             AERIN_ACK,
  output logic             TIMEOUT_ERR,
  output logic             OVERRUN_ERR
);

  localparam int unsigned CNT_W = (ACK_TIMEOUT == 0) ? 1 : $clog2(ACK_TIMEOUT + 1);

  arb_state_t       state;
  grant_t           grant;
  grant_t           last_grant;
  logic [CNT_W-1:0] cnt;

  logic             enc_pend, host_pend;
  logic [AER_W-1:0] enc_addr, host_addr;
  logic             enc_ovr, host_ovr;

  logic             both_c;
  grant_t           pick_c;
  logic [CNT_W-1:0] cnt_inc_c;
  logic             timeout_c;
  logic             rel_done_c;
  logic             abort_c;
  logic             clr_any_c;
  logic             enc_clr_c, host_clr_c;

  aer_req_slot #(.AER_W(AER_W)) u_enc_slot (
    .CLK       (CLK),
    .RST       (RST),
    .VALID     (ENC_VALID),
    .ADDR      (ENC_ADDR),
    .CLR       (enc_clr_c),
    .PENDING   (enc_pend),
    .SLOT_ADDR (enc_addr),
    .OVERRUN   (enc_ovr)
  );

  aer_req_slot #(.AER_W(AER_W)) u_host_slot (
    .CLK       (CLK),
    .RST       (RST),
    .VALID     (HOST_VALID),
    .ADDR      (HOST_ADDR),
    .CLR       (host_clr_c),
    .PENDING   (host_pend),
    .SLOT_ADDR (host_addr),
    .OVERRUN   (host_ovr)
  );

  assign ENC_BUSY  = enc_pend;
  assign HOST_BUSY = host_pend;

  // Round-robin pointer only moves on contested grants.
  assign both_c = enc_pend & host_pend;
  always_comb begin
    pick_c = GRANT_HOST;
    if (both_c)        pick_c = (last_grant == GRANT_HOST) ? GRANT_ENC : GRANT_HOST;
    else if (enc_pend) pick_c = GRANT_ENC;
  end

  assign cnt_inc_c  = cnt + CNT_W'(1);
  assign timeout_c  = (ACK_TIMEOUT != 0) && (cnt_inc_c == CNT_W'(ACK_TIMEOUT));
  assign rel_done_c = (state == RELEASE) && !AERIN_ACK;
  assign abort_c    = timeout_c &&
                      (((state == REQ) && !AERIN_ACK) || ((state == RELEASE) && AERIN_ACK));
  assign clr_any_c  = rel_done_c | abort_c;
  assign enc_clr_c  = clr_any_c && (grant == GRANT_ENC);
  assign host_clr_c = clr_any_c && (grant == GRANT_HOST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      grant       <= GRANT_ENC;
      last_grant  <= GRANT_HOST;
      cnt         <= '0;
      AERIN_REQ   <= 1'b0;
      AERIN_ADDR  <= '0;
      TIMEOUT_ERR <= 1'b0;
      OVERRUN_ERR <= 1'b0;
    end else begin
      if (enc_ovr || host_ovr) OVERRUN_ERR <= 1'b1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (enc_pend || host_pend) begin
            state      <= REQ;
            grant      <= pick_c;
            AERIN_REQ  <= 1'b1;
            AERIN_ADDR <= (pick_c == GRANT_ENC) ? enc_addr : host_addr;
            if (both_c) last_grant <= pick_c;
          end
        end
        REQ: begin
          if (AERIN_ACK) begin
            state     <= RELEASE;
            AERIN_REQ <= 1'b0;
            cnt       <= '0;
          end else if (abort_c) begin
            state       <= IDLE;
            AERIN_REQ   <= 1'b0;
            cnt         <= '0;
            TIMEOUT_ERR <= 1'b1;
          end else begin
            cnt <= cnt_inc_c;
          end
        end
        RELEASE: begin
          if (!AERIN_ACK) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (abort_c) begin
            state       <= IDLE;
            cnt         <= '0;
            TIMEOUT_ERR <= 1'b1;
          end else begin
            cnt <= cnt_inc_c;
          end
        end
        default: begin
          state     <= IDLE;
          AERIN_REQ <= 1'b0;
          cnt       <= '0;
        end
      endcase
    end
  end

endmodule
